// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver FSM state type.
// Optional build macro: UART_RX_PARITY_EN adds the PARITY state (even parity).
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = 3;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
module uart_rx_tick #(
  parameter int unsigned SYSTEM_CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE         = 115200,
  parameter int unsigned OVERSAMPLE        = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV_RAW = SYSTEM_CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..DIV-1 and flag the wrap cycle.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Divider state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8-bit LSB-first frames with valid/ready output.
// Optional build macro: UART_RX_PARITY_EN (even parity bit after the data).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYSTEM_CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE         = 115200,
  parameter int unsigned OVERSAMPLE        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned SMP_W = $clog2(OVERSAMPLE);

  logic                 tick;
  logic                 rx_s1_q, rx_s2_q;
  logic                 rx_sync;
  uart_state_e          state_q, state_d;
  logic [SMP_W-1:0]     smp_cnt_q, smp_cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  uart_rx_tick #(
    .SYSTEM_CLOCK_FREQ (SYSTEM_CLOCK_FREQ),
    .BAUD_RATE         (BAUD_RATE),
    .OVERSAMPLE        (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign rx_sync = rx_s2_q;

  // Frame sequencing and output handshake.
  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q && !ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_sync) begin
            state_d   = START;
            smp_cnt_d = '0;
          end
        end
        START: begin
          if (smp_cnt_q == SMP_W'(OVERSAMPLE / 2 - 1)) begin
            smp_cnt_d = '0;
            if (!rx_sync) begin
              state_d   = DATA;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
        DATA: begin
          if (smp_cnt_q == SMP_W'(OVERSAMPLE - 1)) begin
            smp_cnt_d = '0;
            shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (smp_cnt_q == SMP_W'(OVERSAMPLE - 1)) begin
            smp_cnt_d = '0;
            par_d     = rx_sync;
            state_d   = STOP;
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
`endif
        STOP: begin
          if (smp_cnt_q == SMP_W'(OVERSAMPLE - 1)) begin
            smp_cnt_d = '0;
            state_d   = IDLE;
            if (!rx_sync) begin
              frame_err_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_q ^ (^shift_q)) begin
              parity_err_d = 1'b1;
            end
`endif
            else if (valid_q && !ready) begin
              overrun_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronizer, FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      state_q     <= IDLE;
      smp_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level outcome model plus cycle monitor.
module tb_uart_rx;

  localparam int BIT = 864;
  localparam int EV_BYTE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;
  localparam int EV_OVR  = 3;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  bit m_valid;

  logic       valid_p, ready_p, ferr_p, perr_p, ovr_p;
  logic [7:0] data_p;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_event(input int kind, input logic [7:0] d);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual=kind%0d/%0h required=none", kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e != kind * 256 + int'(d)) begin
        failures++;
        $display("FAIL event actual=kind%0d/%0h required=kind%0d/%0h", kind, d, e / 256, e % 256);
      end
    end
  endtask

  // Frame outcome from the receiver's rules, given the consumer state at completion.
  task automatic model_frame(input logic [7:0] b, input bit stop, input bit par);
    if (!stop) exp_q.push_back(EV_FERR * 256);
    else if (PAR_EN && ((^b) ^ par)) exp_q.push_back(EV_PERR * 256);
    else if (m_valid && !ready) exp_q.push_back(EV_OVR * 256);
    else begin
      exp_q.push_back(EV_BYTE * 256 + int'(b));
      m_valid = !ready;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit par);
    model_frame(b, stop, par);
    rx = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(BIT);
    end
    if (PAR_EN) begin
      rx = par;
      cycles(BIT);
    end
    rx = stop;
    cycles(BIT);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    cycles(400);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Per-cycle monitor: turns DUT outputs into events and checks invariants.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (valid && (!valid_p || ready_p)) check_event(EV_BYTE, data);
      if (frame_err) check_event(EV_FERR, 8'h00);
      if (parity_err) check_event(EV_PERR, 8'h00);
      if (overrun) check_event(EV_OVR, 8'h00);
      if (valid && valid_p && !ready_p) check("data_stable", 32'(data), 32'(data_p));
      if (frame_err && ferr_p) check("ferr_width", 32'(frame_err && ferr_p), 32'd0);
      if (parity_err && perr_p) check("perr_width", 32'(parity_err && perr_p), 32'd0);
      if (overrun && ovr_p) check("ovr_width", 32'(overrun && ovr_p), 32'd0);
    end
    valid_p <= valid;
    ready_p <= ready;
    data_p  <= data;
    ferr_p  <= frame_err;
    perr_p  <= parity_err;
    ovr_p   <= overrun;
  end

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    ready   = 1'b1;
    m_valid = 1'b0;
    cycles(5);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    rst_n = 1'b1;
    cycles(BIT);

    // Plain byte, consumer ready.
    send_frame(8'hA5, 1'b1, ^8'hA5);
    drain("a5_drain");
    check("a5_data", 32'(data), 32'hA5);
    check("a5_valid_low", 32'(valid), 32'd0);

    // Short low glitch is rejected, then a real byte.
    rx = 1'b0;
    cycles(200);
    rx = 1'b1;
    cycles(BIT);
    check("glitch_no_valid", 32'(valid), 32'd0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    drain("3c_drain");
    check("3c_data", 32'(data), 32'h3C);

    // Stop bit low.
    send_frame(8'h55, 1'b0, ^8'h55);
    drain("ferr_drain");
    check("ferr_data_kept", 32'(data), 32'h3C);
    check("ferr_valid_low", 32'(valid), 32'd0);

    // Consumer stalled: second byte overruns.
    ready = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11);
    drain("11_drain");
    send_frame(8'h22, 1'b1, ^8'h22);
    drain("ovr_drain");
    check("ovr_data_kept", 32'(data), 32'h11);
    check("ovr_valid_held", 32'(valid), 32'd1);
    ready   = 1'b1;
    m_valid = 1'b0;
    cycles(3);
    check("ovr_valid_cleared", 32'(valid), 32'd0);

    // Reset during bit 4 of 0xFF, then a clean byte.
    rx = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      cycles(BIT);
    end
    rx = 1'b1;
    cycles(300);
    rst_n = 1'b0;
    cycles(5);
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    cycles(BIT - 305 + 4 * BIT);
    check("midrst_no_valid", 32'(valid), 32'd0);
    send_frame(8'h81, 1'b1, ^8'h81);
    drain("81_drain");
    check("81_data", 32'(data), 32'h81);

`ifdef UART_RX_PARITY_EN
    // Parity mismatch, then correct parity.
    send_frame(8'h07, 1'b1, 1'b0);
    drain("perr_drain");
    check("perr_data_kept", 32'(data), 32'h81);
    send_frame(8'h07, 1'b1, 1'b1);
    drain("07_drain");
    check("07_data", 32'(data), 32'h07);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
